modport_fifo: RTL and testbench
===============================

Name: modport_fifo

Overview:
- Single-clock synchronous FIFO, 128-bit data path, with full/empty and almost-full/almost-empty status flags.
- Sits between a producer driving write strobes with data and a consumer driving read strobes.
- The bench drives i_wren/i_rden/i_wrdata and monitors all outputs on posedge clk.
- Named modport_fifo because "modport" is a SystemVerilog keyword.

Parameters:
- DATA_W, 128, data width of i_wrdata/o_rddata.
- DEPTH, 1024, number of entries; power of two, >= 4.
- ALM_FULL_TH, 4, o_alm_full asserts when free slots <= ALM_FULL_TH.
- ALM_EMPTY_TH, 4, o_alm_empty asserts when occupancy <= ALM_EMPTY_TH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_wren  input  1  write request; sampled at posedge clk.
- i_rden  input  1  read request; sampled at posedge clk.
- i_wrdata  input  DATA_W  write data; captured with i_wren.
- o_full  output  1  FIFO holds DEPTH entries.
- o_empty  output  1  FIFO holds 0 entries.
- o_alm_full  output  1  occupancy >= DEPTH-ALM_FULL_TH.
- o_alm_empty  output  1  occupancy <= ALM_EMPTY_TH.
- o_rddata  output  DATA_W  registered read data.

Behaviour:
- Storage: DEPTH x DATA_W array.
- Pointers: write and read pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
- Occupancy: counter of log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset, when reset=1 at a posedge: pointers=0, count=0, o_rddata=0, o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
  - Reset overrides i_wren/i_rden in the same cycle.
  - Reset mid-operation discards all contents; array contents need not be cleared.
- Write accept: i_wren=1 and o_full=0 at the posedge.
  - i_wrdata is stored at the write pointer, which then increments.
  - A write while full is ignored: no pointer or count change, data dropped.
- Read accept: i_rden=1 and o_empty=0 at the posedge.
  - The entry at the read pointer is loaded into o_rddata, visible after that same edge (1-cycle latency), and the read pointer increments.
  - A read while empty is ignored; o_rddata holds its previous value.
- o_rddata holds its value in every cycle with no accepted read.
- Simultaneous i_wren and i_rden:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: only the write is accepted, count becomes 1. No fall-through: o_rddata is not updated.
  - Full: only the read is accepted, count becomes DEPTH-1. The write is dropped.
- Count update: +1 for an accepted write only, -1 for an accepted read only, otherwise unchanged.
- Flags:
  - Decoded combinationally from the registered count, so they change right after the edge that changed count.
  - o_full = (count==DEPTH); o_empty = (count==0).
  - o_alm_full = (count >= DEPTH-ALM_FULL_TH); o_alm_full remains 1 while o_full=1.
  - o_alm_empty = (count <= ALM_EMPTY_TH); o_alm_empty remains 1 while o_empty=1.
- Ordering: strict first-in first-out across any number of pointer wraps.
- No X may propagate to outputs after reset.
- Inputs are launched from the bench with a #1 output skew after posedge; the design samples only on posedge clk.

Test Plan:
- Reset check: hold reset=1 for 2 cycles with i_wren=1 and i_wrdata=128'hA5 -> o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0, and no entry stored.
- Single write/read: write 128'h1234, then pulse i_rden one cycle later.
  - After the write edge: o_empty=0 and o_alm_empty=1.
  - After the read edge: o_rddata=128'h1234, o_empty=1.
- Fill to full: 1024 writes of an incrementing value 0..1023.
  - o_alm_full rises after write #1020 (count 1020).
  - o_full rises after write #1024.
  - A 1025th write (value 128'hDEAD) is dropped.
  - Draining then returns 0..1023 in order, never 128'hDEAD.
- Read on empty: i_rden=1 for 3 cycles on an empty FIFO after reading 128'h55 -> o_rddata stays 128'h55, o_empty stays 1, count stays 0.
- Simultaneous read/write:
  - At count=5: 10 cycles of concurrent writes and reads -> count stays 5 and read data stays in FIFO order.
  - At count=0 with both strobes: count becomes 1, o_rddata unchanged.
  - At count=1024 with both strobes: count becomes 1023, write data dropped.
- Wrap and mid-op reset:
  - Do 3000 mixed operations crossing the pointer wrap; the output order must match a scoreboard queue.
  - Then assert reset while count=700 -> next cycle o_empty=1, and a subsequent write/read returns only the new data.

Source files
------------

// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with full/empty and almost-full/almost-empty flags.
// Read data is registered: an accepted read updates o_rddata right after its edge.
module modport_fifo #(
   parameter int unsigned DATA_W       = 128,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned ALM_FULL_TH  = 4,
   parameter int unsigned ALM_EMPTY_TH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wren,
   input  logic              i_rden,
   input  logic [DATA_W-1:0] i_wrdata,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_alm_full,
   output logic              o_alm_empty,
   output logic [DATA_W-1:0] o_rddata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] CntFull     = CW'(DEPTH);
   localparam logic [CW-1:0] CntAlmFull  = CW'(DEPTH - ALM_FULL_TH);
   localparam logic [CW-1:0] CntAlmEmpty = CW'(ALM_EMPTY_TH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] rddata_q, rddata_d;
   logic              wr_acc, rd_acc;

   // Flags come straight from the registered count, so they settle just after the edge.
   always_comb begin
      o_full      = (count_q == CntFull);
      o_empty     = (count_q == '0);
      o_alm_full  = (count_q >= CntAlmFull);
      o_alm_empty = (count_q <= CntAlmEmpty);
      o_rddata    = rddata_q;
   end

   always_comb begin
      wr_acc   = i_wren && !o_full;
      rd_acc   = i_rden && !o_empty;
      wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
      rddata_d = rd_acc ? mem_q[rd_ptr_q] : rddata_q;
      count_d  = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rddata_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rddata_q <= rddata_d;
      end
   end

   // Storage is not reset; a write coinciding with reset is still suppressed.
   always_ff @(posedge clk) begin
      if (wr_acc && !reset) begin
         mem_q[wr_ptr_q] <= i_wrdata;
      end
   end

endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo: one task per scenario, inline checks against
// hand-computed values and a small queue model of the FIFO contents.
module tb_modport_fifo;

   localparam int unsigned DATA_W = 128;
   localparam int unsigned DEPTH  = 1024;

   logic              clk;
   logic              reset;
   logic              i_wren;
   logic              i_rden;
   logic [DATA_W-1:0] i_wrdata;
   logic              o_full;
   logic              o_empty;
   logic              o_alm_full;
   logic              o_alm_empty;
   logic [DATA_W-1:0] o_rddata;

   int vectors;
   int miscompares;

   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] exp_rd;

   modport_fifo #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .ALM_FULL_TH (4),
      .ALM_EMPTY_TH(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_wren     (i_wren),
      .i_rden     (i_rden),
      .i_wrdata   (i_wrdata),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_alm_full (o_alm_full),
      .o_alm_empty(o_alm_empty),
      .o_rddata   (o_rddata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {full, empty, alm_full, alm_empty} expected from the model occupancy.
   function automatic logic [3:0] mflags();
      int n;
      n = q.size();
      return {n == DEPTH, n == 0, n >= DEPTH - 4, n <= 4};
   endfunction

   // One clock: drive strobes, update the model at the edge, settle #1 after it.
   task automatic cyc(input bit wr, input bit rd, input logic [DATA_W-1:0] d);
      bit full, empty;
      i_wren   = wr;
      i_rden   = rd;
      i_wrdata = d;
      full     = (q.size() == DEPTH);
      empty    = (q.size() == 0);
      @(posedge clk);
      if (rd && !empty) exp_rd = q.pop_front();
      if (wr && !full) q.push_back(d);
      #1;
      i_wren = 1'b0;
      i_rden = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      i_wren   = 1'b1;
      i_rden   = 1'b0;
      i_wrdata = 128'hA5;
      repeat (n) @(posedge clk);
      #1;
      reset  = 1'b0;
      i_wren = 1'b0;
      q.delete();
      exp_rd = '0;
   endtask

   task automatic test_reset();
      do_reset(2);
      vectors++;
      if ({o_full, o_empty, o_alm_full, o_alm_empty} !== 4'b0101) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 0101",
                  {o_full, o_empty, o_alm_full, o_alm_empty});
      end
      vectors++;
      if (o_rddata !== '0) begin
         miscompares++;
         $display("FAIL reset_rddata: got %h expected 0", o_rddata);
      end
      cyc(0, 1, '0);
      vectors++;
      if (o_empty !== 1'b1 || o_rddata !== '0) begin
         miscompares++;
         $display("FAIL reset_no_store: got empty=%b rddata=%h expected empty=1 rddata=0",
                  o_empty, o_rddata);
      end
   endtask

   task automatic test_single();
      cyc(1, 0, 128'h1234);
      vectors++;
      if (o_empty !== 1'b0 || o_alm_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL single_write: got empty=%b alm_empty=%b expected 0 1",
                  o_empty, o_alm_empty);
      end
      cyc(0, 1, '0);
      vectors++;
      if (o_rddata !== 128'h1234 || o_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL single_read: got rddata=%h empty=%b expected 1234 1", o_rddata, o_empty);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 0, DATA_W'(i));
         vectors++;
         if (o_alm_full !== (i + 1 >= 1020) || o_full !== (i + 1 == 1024)) begin
            miscompares++;
            $display("FAIL fill_flags[%0d]: got alm_full=%b full=%b expected %b %b", i + 1,
                     o_alm_full, o_full, (i + 1 >= 1020), (i + 1 == 1024));
         end
      end
      cyc(1, 0, 128'hDEAD);
      vectors++;
      if (o_full !== 1'b1 || o_alm_full !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_overflow: got full=%b alm_full=%b expected 1 1", o_full, o_alm_full);
      end
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 1, '0);
         vectors++;
         if (o_rddata !== DATA_W'(i)) begin
            miscompares++;
            $display("FAIL drain[%0d]: got %h expected %h", i, o_rddata, DATA_W'(i));
         end
      end
      cyc(0, 1, '0);
      vectors++;
      if (o_rddata !== DATA_W'(1023) || o_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_end: got rddata=%h empty=%b expected 3ff 1", o_rddata, o_empty);
      end
   endtask

   task automatic test_read_empty();
      cyc(1, 0, 128'h55);
      cyc(0, 1, '0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, '0);
         vectors++;
         if (o_rddata !== 128'h55 || o_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL read_empty[%0d]: got rddata=%h empty=%b expected 55 1", i,
                     o_rddata, o_empty);
         end
      end
      cyc(1, 0, 128'h77);
      cyc(0, 1, '0);
      vectors++;
      if (o_rddata !== 128'h77 || o_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL read_empty_count: got rddata=%h empty=%b expected 77 1",
                  o_rddata, o_empty);
      end
   endtask

   task automatic test_simul();
      logic [DATA_W-1:0] e;
      for (int i = 0; i < 5; i++) cyc(1, 0, DATA_W'(100 + i));
      for (int i = 0; i < 10; i++) begin
         cyc(1, 1, DATA_W'(200 + i));
         e = (i < 5) ? DATA_W'(100 + i) : DATA_W'(200 + i - 5);
         vectors++;
         if (o_rddata !== e || {o_full, o_empty, o_alm_full, o_alm_empty} !== 4'b0000) begin
            miscompares++;
            $display("FAIL simul5[%0d]: got rddata=%h flags=%b expected %h 0000", i,
                     o_rddata, {o_full, o_empty, o_alm_full, o_alm_empty}, e);
         end
      end
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, '0);
         vectors++;
         if (o_rddata !== DATA_W'(205 + i) || o_empty !== (i == 4)) begin
            miscompares++;
            $display("FAIL simul5_drain[%0d]: got rddata=%h empty=%b expected %h %b", i,
                     o_rddata, o_empty, DATA_W'(205 + i), (i == 4));
         end
      end
      cyc(1, 1, 128'h300);
      vectors++;
      if (o_rddata !== DATA_W'(209) || o_empty !== 1'b0 || o_alm_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_empty: got rddata=%h empty=%b expected d1 0", o_rddata, o_empty);
      end
      cyc(0, 1, '0);
      vectors++;
      if (o_rddata !== 128'h300 || o_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_empty_read: got rddata=%h empty=%b expected 300 1",
                  o_rddata, o_empty);
      end
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, DATA_W'(1000 + i));
      cyc(1, 1, 128'hBEEF);
      vectors++;
      if (o_rddata !== DATA_W'(1000) || o_full !== 1'b0 || o_alm_full !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_full: got rddata=%h full=%b alm_full=%b expected 3e8 0 1",
                  o_rddata, o_full, o_alm_full);
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         cyc(0, 1, '0);
         vectors++;
         if (o_rddata !== DATA_W'(1001 + i)) begin
            miscompares++;
            $display("FAIL simul_full_drain[%0d]: got %h expected %h", i, o_rddata,
                     DATA_W'(1001 + i));
         end
      end
      cyc(0, 1, '0);
      vectors++;
      if (o_rddata !== DATA_W'(2023) || o_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_full_end: got rddata=%h empty=%b expected 7e7 1",
                  o_rddata, o_empty);
      end
   endtask

   task automatic test_wrap_reset();
      bit wr, rd;
      logic [DATA_W-1:0] d;
      int guard;
      for (int i = 0; i < 3000; i++) begin
         wr = ($urandom_range(0, 99) < 60);
         rd = ($urandom_range(0, 99) < 50);
         d  = {$urandom, $urandom, $urandom, $urandom};
         cyc(wr, rd, d);
         vectors++;
         if (o_rddata !== exp_rd || {o_full, o_empty, o_alm_full, o_alm_empty} !== mflags()) begin
            miscompares++;
            $display("FAIL wrap[%0d]: got rddata=%h flags=%b expected %h %b", i, o_rddata,
                     {o_full, o_empty, o_alm_full, o_alm_empty}, exp_rd, mflags());
         end
      end
      guard = 0;
      while (q.size() != 700 && guard < 3000) begin
         cyc(q.size() < 700, q.size() > 700, DATA_W'(guard));
         guard++;
      end
      vectors++;
      if (q.size() != 700 || o_empty !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_reach700: got size=%0d empty=%b expected 700 0", q.size(), o_empty);
      end
      do_reset(1);
      vectors++;
      if ({o_full, o_empty, o_alm_full, o_alm_empty} !== 4'b0101 || o_rddata !== '0) begin
         miscompares++;
         $display("FAIL midop_reset: got flags=%b rddata=%h expected 0101 0",
                  {o_full, o_empty, o_alm_full, o_alm_empty}, o_rddata);
      end
      cyc(1, 0, 128'hC0FFEE);
      cyc(0, 1, '0);
      vectors++;
      if (o_rddata !== 128'hC0FFEE || o_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_data: got rddata=%h empty=%b expected c0ffee 1",
                  o_rddata, o_empty);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      i_wren      = 1'b0;
      i_rden      = 1'b0;
      i_wrdata    = '0;
      exp_rd      = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_fill();
      test_read_empty();
      test_simul();
      test_wrap_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
